// File: rtl/booth_cu.sv
// ---------------------------------------------------------------------------
// booth_cu : control unit sequencing a radix-2 Booth multiplier datapath.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   launch a multiply (only honoured in IDLE)
//   Q1     in   datapath Q[0]
//   Q0     in   datapath appended bit Q[-1]
//   count  in   datapath iteration counter has reached zero
//   CV     out  registered control vector {rst_c, add, sub, load, shift, dc}
//   busy   out  high whenever the FSM is not in IDLE
//   done   out  one-cycle completion pulse
//   err    out  sticky sequencing fault (count disagreed with iterations)
// ---------------------------------------------------------------------------
module booth_cu #(
    parameter int N_BITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       Q1,
    input  logic       Q0,
    input  logic       count,
    output logic [5:0] CV,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int IW = $clog2(N_BITS) + 1;

    localparam logic [5:0] CV_CLR   = 6'b100000;
    localparam logic [5:0] CV_ADD   = 6'b010000;
    localparam logic [5:0] CV_SUB   = 6'b001000;
    localparam logic [5:0] CV_LOAD  = 6'b000100;
    localparam logic [5:0] CV_SHIFT = 6'b000011;

    typedef enum logic [3:0] {
        IDLE, CLR, LOAD, EVAL, ADD, SUB, SHIFT, CHECK, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   iter_q,  iter_d;
    logic            err_q,   err_d;
    logic [5:0]      cv_q,    cv_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic            iter_full;

    assign iter_full = (iter_q == IW'(N_BITS));

    // Next-state logic. Outputs are decoded from the next state and then
    // registered, so CV/busy/done line up with the state they describe.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLR;
                    iter_d  = '0;
                    err_d   = 1'b0;  // err reads 0 from the CLR cycle on
                end
            end
            CLR:  state_d = LOAD;
            LOAD: state_d = EVAL;
            EVAL: begin
                unique case ({Q1, Q0})
                    2'b10:   state_d = SUB;
                    2'b01:   state_d = ADD;
                    default: state_d = SHIFT;
                endcase
            end
            ADD:  state_d = SHIFT;
            SUB:  state_d = SHIFT;
            SHIFT: begin
                iter_d  = iter_q + IW'(1);
                state_d = CHECK;
            end
            CHECK: begin
                // Finish when either side claims completion; it is a fault
                // unless both the datapath counter and our count agree.
                if (count || iter_full) begin
                    state_d = DONE;
                    err_d   = !(count && iter_full);
                end else begin
                    state_d = EVAL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cv_d = '0;
        unique case (state_d)
            CLR:     cv_d = CV_CLR;
            LOAD:    cv_d = CV_LOAD;
            ADD:     cv_d = CV_ADD;
            SUB:     cv_d = CV_SUB;
            SHIFT:   cv_d = CV_SHIFT;
            default: cv_d = '0;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
            err_q   <= 1'b0;
            cv_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
            cv_q    <= cv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign CV   = cv_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule
